// File: rtl/int_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter.
// The INT_ID_* values must stay aligned with the CPU CSR INT_* encodings.
package int_arbiter_pkg;

   localparam int N_SRC   = 3;
   localparam int ID_BITS = 3;
   localparam int IDX_W   = $clog2(N_SRC);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARB     = 2'd1,
      REQ     = 2'd2,
      SERVICE = 2'd3
   } state_t;

   localparam logic [ID_BITS-1:0] INT_ID_NONE  = 3'd0;
   localparam logic [ID_BITS-1:0] INT_ID_DMA   = 3'd1;
   localparam logic [ID_BITS-1:0] INT_ID_EPU   = 3'd2;
   localparam logic [ID_BITS-1:0] INT_ID_SCTRL = 3'd3;

   localparam logic CFG_SEL_MASK = 1'b0;
   localparam logic CFG_SEL_MODE = 1'b1;

   // Source index to the ID reported to the CSR.
   function automatic logic [ID_BITS-1:0] idx_to_id(input logic [IDX_W-1:0] idx);
      logic [ID_BITS-1:0] id;
      case (idx)
         2'd0:    id = INT_ID_DMA;
         2'd1:    id = INT_ID_EPU;
         2'd2:    id = INT_ID_SCTRL;
         default: id = INT_ID_NONE;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/int_arb_pick.sv
// Combinational winner select. With INT_ARB_RR_EN the search starts at ptr and
// wraps; otherwise the lowest requesting index wins and there is no pointer port.
module int_arb_pick
   import int_arbiter_pkg::*;
(
   input  logic [N_SRC-1:0] req,
`ifdef INT_ARB_RR_EN
   input  logic [IDX_W-1:0] ptr,
`endif
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

`ifdef INT_ARB_RR_EN
   // Rotating search: first requester at or after ptr, wrapping at N_SRC.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         int j;
         j = (int'(ptr) + k) % N_SRC;
         if (!valid && req[j]) begin
            valid = 1'b1;
            idx   = IDX_W'(j);
         end
      end
   end
`else
   // Fixed priority: scan downwards so the lowest requesting index is kept last.
   always_comb begin
      idx   = '0;
      valid = |req;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (req[k]) idx = IDX_W'(k);
      end
   end
`endif

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter in front of the CSR unit: synchronises device lines,
// latches pending (edge or level), masks, picks one winner and holds it in
// service until mret. Optional round-robin via define INT_ARB_RR_EN.
//
// state   | meaning
// IDLE    | nothing offered, waiting for any enabled pending source
// ARB     | winner being registered
// REQ     | int_taken_o raised to CSR, waiting for ack
// SERVICE | trap entered, waiting for mret
module int_arbiter
   import int_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               rstn,
   input  logic [N_SRC-1:0]   irq_i,
   input  logic               cfg_we_i,
   input  logic               cfg_sel_i,
   input  logic [N_SRC-1:0]   cfg_wdata_i,
   input  logic               int_ack_i,
   input  logic               mret_i,
   output logic               int_taken_o,
   output logic [ID_BITS-1:0] int_id_o,
   output logic [N_SRC-1:0]   pending_o,
   output logic               busy_o
);

   logic [N_SRC-1:0] sync1, sync2, sync_dly;
   logic [N_SRC-1:0] enable, mode, pending;
   logic [N_SRC-1:0] req, edge_det, ack_clr;
   logic [IDX_W-1:0] winner, pick_idx;
   logic             pick_valid;
   state_t           state, state_nxt;

   assign edge_det = sync2 & ~sync_dly;
   assign req      = pending & enable;

   // Two-flop synchroniser plus one delay stage for edge detection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1    <= '0;
         sync2    <= '0;
         sync_dly <= '0;
      end else begin
         sync1    <= irq_i;
         sync2    <= sync1;
         sync_dly <= sync2;
      end
   end

   // Configuration registers: enable mask and trigger mode.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         enable <= '0;
         mode   <= '0;
      end else if (cfg_we_i) begin
         if (cfg_sel_i == CFG_SEL_MASK) enable <= cfg_wdata_i;
         else                           mode   <= cfg_wdata_i;
      end
   end

   // Ack of the offered winner clears its edge-mode pending bit.
   always_comb begin
      ack_clr = '0;
      if (state == REQ && int_ack_i) ack_clr[winner] = 1'b1;
   end

   // Pending latch; a mode change drops the bit, and a new edge beats the ack clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pending <= '0;
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            if (cfg_we_i && cfg_sel_i == CFG_SEL_MODE && cfg_wdata_i[i] != mode[i])
               pending[i] <= 1'b0;
            else if (mode[i])
               pending[i] <= edge_det[i] | (pending[i] & ~ack_clr[i]);
            else
               pending[i] <= sync2[i];
         end
      end
   end

`ifdef INT_ARB_RR_EN
   logic [IDX_W-1:0] rr_ptr;

   // Round-robin pointer moves past the winner when the CSR takes it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         rr_ptr <= '0;
      else if (state == REQ && int_ack_i)
         rr_ptr <= (winner == IDX_W'(N_SRC - 1)) ? '0 : winner + IDX_W'(1);
   end

   int_arb_pick u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );
`else
   int_arb_pick u_pick (
      .req   (req),
      .idx   (pick_idx),
      .valid (pick_valid)
   );
`endif

   // Winner is captured only in ARB so int_id_o cannot move during REQ/SERVICE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                         winner <= '0;
      else if (state == ARB && pick_valid) winner <= pick_idx;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next state; an ack in the same cycle as a request drop still enters service.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req) state_nxt = ARB;
         ARB:     state_nxt = pick_valid ? REQ : IDLE;
         REQ: begin
            if (int_ack_i)        state_nxt = SERVICE;
            else if (!req[winner]) state_nxt = IDLE;
         end
         SERVICE: if (mret_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign int_taken_o = (state == REQ);
   assign busy_o      = (state == SERVICE);
   assign int_id_o    = (state == REQ || state == SERVICE) ? idx_to_id(winner) : INT_ID_NONE;
   assign pending_o   = pending;

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the interrupt rules.
module tb_int_arbiter;
   import int_arbiter_pkg::*;

   logic               clk = 1'b0;
   logic               rstn;
   logic [N_SRC-1:0]   irq;
   logic               cfg_we, cfg_sel;
   logic [N_SRC-1:0]   cfg_wdata;
   logic               int_ack, mret;
   logic               int_taken_o;
   logic [ID_BITS-1:0] int_id_o;
   logic [N_SRC-1:0]   pending_o;
   logic               busy_o;

   int vectors     = 0;
   int miscompares = 0;

   // Model state
   logic [2:0] h1, h2, h3, m_pend, m_mask, m_mode;
   bit         m_choosing, m_offering, m_serving;
   int         m_win, m_ptr;

   always #5 clk = ~clk;

   int_arbiter dut (
      .clk         (clk),
      .rstn        (rstn),
      .irq_i       (irq),
      .cfg_we_i    (cfg_we),
      .cfg_sel_i   (cfg_sel),
      .cfg_wdata_i (cfg_wdata),
      .int_ack_i   (int_ack),
      .mret_i      (mret),
      .int_taken_o (int_taken_o),
      .int_id_o    (int_id_o),
      .pending_o   (pending_o),
      .busy_o      (busy_o)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      h1 = 0; h2 = 0; h3 = 0; m_pend = 0; m_mask = 0; m_mode = 0;
      m_choosing = 0; m_offering = 0; m_serving = 0; m_win = 0; m_ptr = 0;
   endtask

   function automatic int model_pick(input logic [2:0] r, input int p);
      for (int k = 0; k < 3; k++)
         if (r[(p + k) % 3]) return (p + k) % 3;
      return 0;
   endfunction

   // One clock of the interrupt rules, using the values present before the edge.
   task automatic model_tick();
      logic [2:0] r, e, np;
      r = m_pend & m_mask;
      e = h2 & ~h3;
      for (int i = 0; i < 3; i++) begin
         if (cfg_we && cfg_sel && cfg_wdata[i] != m_mode[i]) np[i] = 1'b0;
         else if (m_mode[i]) np[i] = e[i] | (m_pend[i] & !(m_offering && int_ack && m_win == i));
         else np[i] = h2[i];
      end
      if (m_serving) begin
         if (mret) m_serving = 0;
      end else if (m_offering) begin
         if (int_ack) begin
            m_offering = 0;
            m_serving  = 1;
`ifdef INT_ARB_RR_EN
            m_ptr = (m_win + 1) % 3;
`endif
         end else if (!r[m_win]) begin
            m_offering = 0;
         end
      end else if (m_choosing) begin
         m_choosing = 0;
         if (r != 0) begin
            m_offering = 1;
            m_win = model_pick(r, m_ptr);
         end
      end else if (r != 0) begin
         m_choosing = 1;
      end
      h3 = h2; h2 = h1; h1 = irq;
      m_pend = np;
      if (cfg_we) begin
         if (cfg_sel) m_mode = cfg_wdata;
         else         m_mask = cfg_wdata;
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         model_tick();
         @(negedge clk);
         chk("taken", 8'(int_taken_o), 8'(m_offering));
         chk("id", 8'(int_id_o), (m_offering || m_serving) ? 8'(m_win + 1) : 8'd0);
         chk("pending", 8'(pending_o), 8'(m_pend));
         chk("busy", 8'(busy_o), 8'(m_serving));
      end
   endtask

   task automatic cfg(input logic sel, input logic [2:0] data);
      cfg_we = 1; cfg_sel = sel; cfg_wdata = data;
      step(1);
      cfg_we = 0; cfg_wdata = 0;
   endtask

   task automatic ack_pulse();
      int_ack = 1; step(1); int_ack = 0;
   endtask

   task automatic mret_pulse();
      mret = 1; step(1); mret = 0;
   endtask

   initial begin
      int n;
      int exp5 [4];
      int first3, second3;
      irq = 0; cfg_we = 0; cfg_sel = 0; cfg_wdata = 0; int_ack = 0; mret = 0;
      rstn = 0;
      model_reset();
      #12;
      chk("rst_taken", 8'(int_taken_o), 8'd0);
      chk("rst_id", 8'(int_id_o), 8'd0);
      chk("rst_pending", 8'(pending_o), 8'd0);
      chk("rst_busy", 8'(busy_o), 8'd0);
      @(negedge clk);
      rstn = 1;

      // 1: masked level source latches pending but is never offered
      irq = 3'b001;
      step(3);
      chk("t1_pending", 8'(pending_o), 8'h01);
      step(3);
      chk("t1_taken", 8'(int_taken_o), 8'd0);
      irq = 0;
      step(4);

      // 2: edge pulse on source 1
      cfg(CFG_SEL_MASK, 3'b111);
      cfg(CFG_SEL_MODE, 3'b111);
      irq = 3'b010; step(1); irq = 0;
      step(2);
      chk("t2_pending", 8'(pending_o), 8'h02);
      step(2);
      chk("t2_taken", 8'(int_taken_o), 8'd1);
      chk("t2_id", 8'(int_id_o), 8'd2);
      ack_pulse();
      chk("t2_busy", 8'(busy_o), 8'd1);
      chk("t2_pend_clr", 8'(pending_o), 8'd0);
      mret_pulse();
      chk("t2_idle", 8'(busy_o), 8'd0);

      // 3: simultaneous edges on sources 0 and 2
`ifdef INT_ARB_RR_EN
      first3 = 3; second3 = 1;
`else
      first3 = 1; second3 = 3;
`endif
      irq = 3'b101; step(1); irq = 0;
      step(4);
      chk("t3_first_taken", 8'(int_taken_o), 8'd1);
      chk("t3_first_id", 8'(int_id_o), 8'(first3));
      ack_pulse();
      step(2);
      mret_pulse();
      step(2);
      chk("t3_second_taken", 8'(int_taken_o), 8'd1);
      chk("t3_second_id", 8'(int_id_o), 8'(second3));
      ack_pulse();
      mret_pulse();

      // 4: level source drops while offered
      cfg(CFG_SEL_MODE, 3'b011);
      irq = 3'b100;
      step(5);
      chk("t4_taken", 8'(int_taken_o), 8'd1);
      chk("t4_id", 8'(int_id_o), 8'd3);
      irq = 0;
      step(3);
      chk("t4_still", 8'(int_taken_o), 8'd1);
      step(1);
      chk("t4_drop", 8'(int_taken_o), 8'd0);
      chk("t4_busy", 8'(busy_o), 8'd0);
      step(3);

      // 5: fresh reset, all sources level and held
      rstn = 0;
      #1;
      model_reset();
      chk("rst2_pending", 8'(pending_o), 8'd0);
      @(negedge clk);
      rstn = 1;
`ifdef INT_ARB_RR_EN
      exp5 = '{1, 2, 3, 1};
`else
      exp5 = '{1, 1, 1, 1};
`endif
      cfg(CFG_SEL_MASK, 3'b111);
      irq = 3'b111;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!int_taken_o && n < 12) begin
            step(1);
            n++;
         end
         chk("t5_taken", 8'(int_taken_o), 8'd1);
         chk("t5_id", 8'(int_id_o), 8'(exp5[k]));
         ack_pulse();
         mret_pulse();
      end
      irq = 0;
      step(5);

      // 6: new edge lands in the ack cycle
      cfg(CFG_SEL_MODE, 3'b111);
      irq = 3'b010; step(1); irq = 0;
      step(4);
      chk("t6_taken", 8'(int_taken_o), 8'd1);
      irq = 3'b010; step(1); irq = 0;
      step(1);
      ack_pulse();
      chk("t6_pending", 8'(pending_o), 8'h02);
      chk("t6_busy", 8'(busy_o), 8'd1);
      mret_pulse();
      step(2);
      chk("t6_retaken", 8'(int_taken_o), 8'd1);
      chk("t6_id", 8'(int_id_o), 8'd2);
      ack_pulse();
      mret_pulse();

      // Random traffic against the model
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) irq = 3'($urandom_range(0, 7));
         cfg_we    = ($urandom_range(0, 15) == 0);
         cfg_sel   = 1'($urandom_range(0, 1));
         cfg_wdata = 3'($urandom_range(0, 7));
         int_ack   = ($urandom_range(0, 3) == 0);
         mret      = ($urandom_range(0, 3) == 0);
         step(1);
      end
      cfg_we = 0; int_ack = 0; mret = 0; irq = 0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
